// File: rtl/wb_arbiter2_if.sv
// rtl/wb_arbiter2_if.sv - pipelined Wishbone bus bundle with master/slave views
interface wb_arbiter2_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic [DW/8-1:0] sel;
   logic          stall;
   logic          ack;
   logic          err;
   logic [DW-1:0] dat_r;

   // the device that starts cycles
   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  stall, ack, err, dat_r
   );

   // the device that answers cycles
   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output stall, ack, err, dat_r
   );
endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master pipelined Wishbone arbiter (WB_ARB_FIXED_PRIO_EN selects fixed m0 priority)
module wb_arbiter2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MAX_OUT = 4
) (
   input  logic          clk,
   input  logic          rst,
   wb_arbiter2_if.slave  m0,
   wb_arbiter2_if.slave  m1,
   wb_arbiter2_if.master s
);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

   typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            w_full;
   logic            w_pending;
   logic            w_cyc;
   logic            w_stb;
   logic            w_we;
   logic [AW-1:0]   w_adr;
   logic [DW-1:0]   w_dat_w;
   logic [DW/8-1:0] w_sel;
   logic            w_accept;
   logic            w_resp;
`ifndef WB_ARB_FIXED_PRIO_EN
   logic            r_last;
`endif

   assign w_full    = (r_cnt == CNT_MAX);
   assign w_pending = (r_cnt != '0);

   // grant selection and combinational routing of the owner onto the shared bus
   always_comb begin
      w_next   = r_state;
      w_cyc    = 1'b0;
      w_stb    = 1'b0;
      w_we     = 1'b0;
      w_adr    = '0;
      w_dat_w  = '0;
      w_sel    = '0;
      m0.stall = 1'b1;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m1.stall = 1'b1;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      case (r_state)
         IDLE: begin
            if (m0.cyc && m1.cyc) begin
`ifdef WB_ARB_FIXED_PRIO_EN
               w_next = G0;
`else
               w_next = r_last ? G0 : G1;
`endif
            end else if (m0.cyc) begin
               w_next = G0;
            end else if (m1.cyc) begin
               w_next = G1;
            end
         end
         G0: begin
            w_cyc    = m0.cyc;
            w_stb    = m0.stb & ~w_full;
            w_we     = m0.we;
            w_adr    = m0.adr;
            w_dat_w  = m0.dat_w;
            w_sel    = m0.sel;
            m0.stall = s.stall | w_full;
            // responses with nothing outstanding belong to an aborted burst
            m0.ack   = s.ack & w_pending;
            m0.err   = s.err & w_pending;
            if (!m0.cyc) w_next = IDLE;
         end
         G1: begin
            w_cyc    = m1.cyc;
            w_stb    = m1.stb & ~w_full;
            w_we     = m1.we;
            w_adr    = m1.adr;
            w_dat_w  = m1.dat_w;
            w_sel    = m1.sel;
            m1.stall = s.stall | w_full;
            m1.ack   = s.ack & w_pending;
            m1.err   = s.err & w_pending;
            if (!m1.cyc) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept = w_stb & ~s.stall;
   assign w_resp   = (s.ack | s.err) & w_pending;

   assign s.cyc    = w_cyc;
   assign s.stb    = w_stb;
   assign s.we     = w_we;
   assign s.adr    = w_adr;
   assign s.dat_w  = w_dat_w;
   assign s.sel    = w_sel;
   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // outstanding request count; any return to IDLE forgets in-flight responses
   always_ff @(posedge clk) begin
      if (rst)                     r_cnt <= '0;
      else if (w_next == IDLE)     r_cnt <= '0;
      else if (w_accept && !w_resp) r_cnt <= r_cnt + CW'(1);
      else if (!w_accept && w_resp) r_cnt <= r_cnt - CW'(1);
   end

`ifndef WB_ARB_FIXED_PRIO_EN
   // remember the most recent owner so a contested grant goes to the other one
   always_ff @(posedge clk) begin
      if (rst)                                  r_last <= 1'b1;
      else if (r_state == IDLE && w_next == G0) r_last <= 1'b0;
      else if (r_state == IDLE && w_next == G1) r_last <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - self-checking bench for wb_arbiter2 (honours WB_ARB_FIXED_PRIO_EN)
module tb_wb_arbiter2;
   localparam int MAX_OUT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_arbiter2_if #(.AW(32), .DW(32)) m0_if ();
   wb_arbiter2_if #(.AW(32), .DW(32)) m1_if ();
   wb_arbiter2_if #(.AW(32), .DW(32)) s_if ();

   wb_arbiter2 #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT)) dut (
      .clk (clk),
      .rst (rst),
      .m0  (m0_if),
      .m1  (m1_if),
      .s   (s_if)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit arb_done;
   int owners[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rdata(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic drive_m(input int id, input logic cyc, input logic stb, input logic [31:0] adr);
      if (id == 0) begin
         m0_if.cyc = cyc; m0_if.stb = stb; m0_if.adr = adr;
         m0_if.we = adr[2]; m0_if.dat_w = ~adr; m0_if.sel = adr[7:4];
      end else begin
         m1_if.cyc = cyc; m1_if.stb = stb; m1_if.adr = adr;
         m1_if.we = adr[2]; m1_if.dat_w = ~adr; m1_if.sel = adr[7:4];
      end
   endtask

   function automatic logic m_stall(input int id);
      return (id == 0) ? m0_if.stall : m1_if.stall;
   endfunction
   function automatic logic m_ack(input int id);
      return (id == 0) ? m0_if.ack : m1_if.ack;
   endfunction
   function automatic logic m_err(input int id);
      return (id == 0) ? m0_if.err : m1_if.err;
   endfunction
   function automatic logic [31:0] m_dat_r(input int id);
      return (id == 0) ? m0_if.dat_r : m1_if.dat_r;
   endfunction

   task automatic idle_inputs();
      drive_m(0, 1'b0, 1'b0, 32'h0);
      drive_m(1, 1'b0, 1'b0, 32'h0);
      s_if.stall = 1'b0; s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_cmp++; if (s_if.cyc !== 1'b0) begin n_bad++; $display("FAIL rst_s_cyc: got %0h want 0", s_if.cyc); end
      n_cmp++; if (m0_if.stall !== 1'b1 || m1_if.stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %0h%0h want 11", m0_if.stall, m1_if.stall); end
      n_cmp++; if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0) begin n_bad++; $display("FAIL rst_resp: got %0h want 0", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}); end
      rst = 1'b0;
      // reset in the middle of a transfer with a response in flight
      drive_m(0, 1'b1, 1'b1, 32'h1234_5674);
      tick();
      tick();
      rst = 1'b1;
      s_if.ack = 1'b1;
      s_if.dat_r = 32'hCAFE_0001;
      tick();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++; if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b0) begin n_bad++; $display("FAIL rst_mid_ctl: got %0h want 0", {s_if.cyc, s_if.stb, s_if.we}); end
         n_cmp++; if ({s_if.adr, s_if.dat_w, s_if.sel} !== 68'h0) begin n_bad++; $display("FAIL rst_mid_bus: got %0h want 0", {s_if.adr, s_if.dat_w, s_if.sel}); end
         n_cmp++; if ({m0_if.stall, m1_if.stall, m0_if.ack, m1_if.ack} !== 4'b1100) begin n_bad++; $display("FAIL rst_mid_master: got %0h want c", {m0_if.stall, m1_if.stall, m0_if.ack, m1_if.ack}); end
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_single_read();
      logic [31:0] a;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         a = (i == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
         d = (i == 0) ? 32'hDEAD_BEEF : $urandom;
         do_reset();
         drive_m(0, 1'b1, 1'b1, a);
         @(negedge clk);
         n_cmp++; if (m0_if.stall !== 1'b1 || s_if.cyc !== 1'b0) begin n_bad++; $display("FAIL rd_grant_wait: got stall=%0h cyc=%0h want 1/0", m0_if.stall, s_if.cyc); end
         tick();
         @(negedge clk);
         n_cmp++; if ({s_if.cyc, s_if.stb, m0_if.stall} !== 3'b110) begin n_bad++; $display("FAIL rd_issue: got %0h want 6", {s_if.cyc, s_if.stb, m0_if.stall}); end
         n_cmp++; if (s_if.adr !== a || s_if.dat_w !== ~a) begin n_bad++; $display("FAIL rd_adr: got %0h/%0h want %0h/%0h", s_if.adr, s_if.dat_w, a, ~a); end
         tick();
         drive_m(0, 1'b1, 1'b0, a);
         s_if.ack = 1'b1;
         s_if.dat_r = d;
         @(negedge clk);
         n_cmp++; if (m0_if.ack !== 1'b1 || m0_if.dat_r !== d) begin n_bad++; $display("FAIL rd_ack: got %0h/%0h want 1/%0h", m0_if.ack, m0_if.dat_r, d); end
         n_cmp++; if (m1_if.ack !== 1'b0 || m1_if.stall !== 1'b1) begin n_bad++; $display("FAIL rd_other: got ack=%0h stall=%0h want 0/1", m1_if.ack, m1_if.stall); end
         tick();
         idle_inputs();
         tick();
      end
   endtask

   task automatic master_run(input int id, input int nbursts);
      int sent;
      int got;
      int cycles;
      logic [31:0] a;
      logic [31:0] e;
      for (int b = 0; b < nbursts; b++) begin
         sent = 0; got = 0; cycles = 0;
         while (got < 3 && cycles < 500) begin
            a = (32'(id) << 28) | (32'(b) << 8) | (32'(sent) << 2);
            drive_m(id, 1'b1, sent < 3, a);
            @(negedge clk);
            if (m_ack(id)) begin
               e = (32'(id) << 28) | (32'(b) << 8) | (32'(got) << 2);
               n_cmp++; if (m_dat_r(id) !== rdata(e)) begin n_bad++; $display("FAIL arb_rdata m%0d: got %0h want %0h", id, m_dat_r(id), rdata(e)); end
               got++;
            end
            if (sent < 3 && !m_stall(id)) sent++;
            tick();
            cycles++;
         end
         n_cmp++; if (got != 3) begin n_bad++; $display("FAIL arb_timeout m%0d: got %0d acks want 3", id, got); end
         drive_m(id, 1'b0, 1'b0, 32'h0);
         tick();
      end
   endtask

   task automatic slave_run();
      logic [31:0] q[$];
      while (!arb_done) begin
         s_if.stall = ($urandom_range(0, 3) == 0);
         s_if.ack   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         s_if.dat_r = s_if.ack ? rdata(q[0]) : $urandom;
         @(negedge clk);
         if (s_if.ack) void'(q.pop_front());
         if (s_if.cyc && s_if.stb && !s_if.stall) q.push_back(s_if.adr);
         tick();
      end
      s_if.stall = 1'b0; s_if.ack = 1'b0;
   endtask

   task automatic monitor_run();
      logic prev = 1'b0;
      int low_run = 0;
      while (!arb_done) begin
         @(negedge clk);
         if (s_if.cyc && !prev) begin
            owners.push_back(int'(s_if.adr[28]));
            if (owners.size() > 1) begin
               n_cmp++; if (low_run != 2) begin n_bad++; $display("FAIL arb_gap: got %0d idle-bus cycles want 2", low_run); end
            end
         end
         low_run = s_if.cyc ? 0 : low_run + 1;
         prev = s_if.cyc;
      end
   endtask

   task automatic test_arbitration();
      int exp_q[$];
      int r0;
      int r1;
      int turn;
      do_reset();
      arb_done = 1'b0;
      owners.delete();
      fork
         begin
            fork
               master_run(0, 2);
               master_run(1, 1);
            join
            arb_done = 1'b1;
         end
         slave_run();
         monitor_run();
      join
      r0 = 2; r1 = 1; turn = 0;
`ifdef WB_ARB_FIXED_PRIO_EN
      repeat (r0) exp_q.push_back(0);
      repeat (r1) exp_q.push_back(1);
`else
      while (r0 > 0 || r1 > 0) begin
         if ((turn == 0 && r0 > 0) || r1 == 0) begin exp_q.push_back(0); r0--; turn = 1; end
         else begin exp_q.push_back(1); r1--; turn = 0; end
      end
`endif
      n_cmp++; if (owners.size() != exp_q.size()) begin n_bad++; $display("FAIL arb_grants: got %0d grants want %0d", owners.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < owners.size(); i++) begin
         n_cmp++; if (owners[i] != exp_q[i]) begin n_bad++; $display("FAIL arb_order[%0d]: got m%0d want m%0d", i, owners[i], exp_q[i]); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      drive_m(0, 1'b1, 1'b1, 32'h40);
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (m0_if.stall !== 1'b0 || s_if.stb !== 1'b1) begin n_bad++; $display("FAIL lim_accept%0d: got stall=%0h stb=%0h want 0/1", k, m0_if.stall, s_if.stb); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (m0_if.stall !== 1'b1 || s_if.stb !== 1'b0) begin n_bad++; $display("FAIL lim_full: got stall=%0h stb=%0h want 1/0", m0_if.stall, s_if.stb); end
      tick();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (m0_if.stall !== 1'b1 || m0_if.ack !== 1'b1) begin n_bad++; $display("FAIL lim_ack: got stall=%0h ack=%0h want 1/1", m0_if.stall, m0_if.ack); end
      tick();
      s_if.ack = 1'b0;
      @(negedge clk);
      n_cmp++; if (m0_if.stall !== 1'b0 || s_if.stb !== 1'b1) begin n_bad++; $display("FAIL lim_fifth: got stall=%0h stb=%0h want 0/1", m0_if.stall, s_if.stb); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_same_cycle();
      int acc;
      do_reset();
      drive_m(0, 1'b1, 1'b1, 32'h80);
      tick();
      tick();
      tick();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (m0_if.stall !== 1'b0 || m0_if.ack !== 1'b1) begin n_bad++; $display("FAIL same_cycle: got stall=%0h ack=%0h want 0/1", m0_if.stall, m0_if.ack); end
      tick();
      s_if.ack = 1'b0;
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!m0_if.stall) acc++;
         tick();
      end
      n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL same_cycle_cnt: got %0d accepts want 2", acc); end
      idle_inputs();
      tick();
   endtask

   task automatic test_abort();
      do_reset();
      drive_m(1, 1'b1, 1'b1, 32'h1000_0010);
      tick();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++; if (m1_if.stall !== 1'b0) begin n_bad++; $display("FAIL abort_issue%0d: got stall=%0h want 0", k, m1_if.stall); end
         tick();
      end
      drive_m(1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      n_cmp++; if (s_if.cyc !== 1'b0) begin n_bad++; $display("FAIL abort_cyc: got %0h want 0", s_if.cyc); end
      tick();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_cmp++; if ({m0_if.ack, m1_if.ack, m1_if.stall, s_if.cyc} !== 4'b0010) begin n_bad++; $display("FAIL abort_late_ack: got %0h want 2", {m0_if.ack, m1_if.ack, m1_if.stall, s_if.cyc}); end
      tick();
      s_if.ack = 1'b0;
      drive_m(0, 1'b1, 1'b0, 32'h20);
      tick();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_cmp++; if ({s_if.cyc, m0_if.ack, m1_if.ack} !== 3'b100) begin n_bad++; $display("FAIL abort_cnt_clear: got %0h want 4", {s_if.cyc, m0_if.ack, m1_if.ack}); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_random_traffic();
      int id;
      int cnt;
      int k;
      bit granted;
      bit acc;
      bit rsp;
      logic stb, st, ak, er;
      logic e_stb, e_stall, e_ack, e_err;
      for (int r = 0; r < 3; r++) begin
         id = $urandom_range(0, 1);
         cnt = 0;
         granted = 1'b0;
         do_reset();
         for (int c = 0; c < 40; c++) begin
            stb = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            k   = $urandom_range(0, 3);
            ak  = (k == 1);
            er  = (k == 2);
            drive_m(id, 1'b1, stb, $urandom);
            s_if.stall = st; s_if.ack = ak; s_if.err = er; s_if.dat_r = $urandom;
            @(negedge clk);
            e_stb   = granted && stb && (cnt < MAX_OUT);
            e_stall = !granted || st || (cnt == MAX_OUT);
            e_ack   = granted && ak && (cnt > 0);
            e_err   = granted && er && (cnt > 0);
            n_cmp++; if (s_if.stb !== e_stb) begin n_bad++; $display("FAIL rnd_stb m%0d c%0d: got %0h want %0h", id, c, s_if.stb, e_stb); end
            n_cmp++; if (m_stall(id) !== e_stall) begin n_bad++; $display("FAIL rnd_stall m%0d c%0d: got %0h want %0h", id, c, m_stall(id), e_stall); end
            n_cmp++; if (m_ack(id) !== e_ack || m_err(id) !== e_err) begin n_bad++; $display("FAIL rnd_resp m%0d c%0d: got %0h%0h want %0h%0h", id, c, m_ack(id), m_err(id), e_ack, e_err); end
            n_cmp++; if ({m_stall(1 - id), m_ack(1 - id), m_err(1 - id)} !== 3'b100) begin n_bad++; $display("FAIL rnd_other m%0d c%0d: got %0h want 4", 1 - id, c, {m_stall(1 - id), m_ack(1 - id), m_err(1 - id)}); end
            acc = e_stb && !st;
            rsp = granted && (ak || er) && (cnt > 0);
            if (granted) cnt = cnt + int'(acc) - int'(rsp);
            granted = 1'b1;
            tick();
         end
         idle_inputs();
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_read();
      test_arbitration();
      test_outstanding_limit();
      test_same_cycle();
      test_abort();
      test_random_traffic();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
